// File: rtl/sobel_stream_ctrl_pkg.sv
// Shared definitions for the Sobel streaming controller.
//   PIXEL_WIDTH_OUT : grayscale pixel width used on both stream sides
//   MAX_PIXEL_VAL   : 2^PIXEL_WIDTH_OUT, magnitudes at or above it saturate
//   IMG_*_DEF       : default frame geometry
//   ctrl_state_t    : controller FSM states
//   clamp_mag()     : saturates a raw |Gx|+|Gy| sum to the pixel range
package sobel_stream_ctrl_pkg;

    localparam int PIXEL_WIDTH_OUT = 8;
    localparam int MAX_PIXEL_VAL   = 256;
    localparam int IMG_WIDTH_DEF   = 16;
    localparam int IMG_HEIGHT_DEF  = 16;

    // Raw magnitude width: each gradient term is at most 4*max, the sum twice that.
    localparam int MAG_W = PIXEL_WIDTH_OUT + 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } ctrl_state_t;

    function automatic logic [PIXEL_WIDTH_OUT-1:0] clamp_mag(input logic [MAG_W-1:0] sum);
        if (sum >= MAG_W'(MAX_PIXEL_VAL))
            return PIXEL_WIDTH_OUT'(MAX_PIXEL_VAL - 1);
        else
            return sum[PIXEL_WIDTH_OUT-1:0];
    endfunction

endpackage

// File: rtl/sobel_stream_ctrl_core.sv
// sobel_core: purely combinational 3x3 Sobel magnitude.
//   i0..i8 : window pixels in row-major order (i0 top-left, i8 bottom-right)
//   mag    : |Gx| + |Gy|, saturated to the pixel range
module sobel_core
    import sobel_stream_ctrl_pkg::*;
(
    input  logic [PIXEL_WIDTH_OUT-1:0] i0,
    input  logic [PIXEL_WIDTH_OUT-1:0] i1,
    input  logic [PIXEL_WIDTH_OUT-1:0] i2,
    input  logic [PIXEL_WIDTH_OUT-1:0] i3,
    input  logic [PIXEL_WIDTH_OUT-1:0] i4,
    input  logic [PIXEL_WIDTH_OUT-1:0] i5,
    input  logic [PIXEL_WIDTH_OUT-1:0] i6,
    input  logic [PIXEL_WIDTH_OUT-1:0] i7,
    input  logic [PIXEL_WIDTH_OUT-1:0] i8,
    output logic [PIXEL_WIDTH_OUT-1:0] mag
);

    localparam int SW = PIXEL_WIDTH_OUT + 3;

    logic [SW-1:0]    gx_pos;
    logic [SW-1:0]    gx_neg;
    logic [SW-1:0]    gy_pos;
    logic [SW-1:0]    gy_neg;
    logic [SW-1:0]    abs_x;
    logic [SW-1:0]    abs_y;
    logic [MAG_W-1:0] sum;

    // The centre tap has zero weight in both kernels.
    logic unused_center;
    assign unused_center = ^i4;

    // Each gradient is split into its positive and negative kernel halves so
    // the absolute value is a compare-and-subtract on unsigned values.
    always_comb begin
        gx_pos = SW'(i2) + SW'({i5, 1'b0}) + SW'(i8);
        gx_neg = SW'(i0) + SW'({i3, 1'b0}) + SW'(i6);
        gy_pos = SW'(i6) + SW'({i7, 1'b0}) + SW'(i8);
        gy_neg = SW'(i0) + SW'({i1, 1'b0}) + SW'(i2);
        abs_x  = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
        abs_y  = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
        sum    = MAG_W'(abs_x) + MAG_W'(abs_y);
        mag    = clamp_mag(sum);
    end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: sequences sobel_core across a raster-scan frame.
//   clk_i, nreset_i : clock (rising edge) and async active-low reset
//   in_valid_i / in_ready_o / in_pixel_i / sof_i : pixel input stream,
//       sof_i marks the current pixel as frame position (0,0)
//   out_valid_o / out_ready_i / out_pixel_o : registered edge magnitude stream
//   frame_done_o : one-cycle pulse after the last pixel of a frame is accepted
module sobel_stream_ctrl
    import sobel_stream_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PIXEL_WIDTH_OUT-1:0] in_pixel_i,
    input  logic                       sof_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PIXEL_WIDTH_OUT-1:0] out_pixel_o,
    output logic                       frame_done_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    ctrl_state_t state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [PIXEL_WIDTH_OUT-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH_OUT-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_WIDTH_OUT-1:0] win [3][3];

    logic                       accept;
    logic                       take;
    logic [COL_W-1:0]           eff_col;
    logic [ROW_W-1:0]           eff_row;
    logic [COL_W-1:0]           next_col;
    logic [ROW_W-1:0]           next_row;
    logic                       line_end;
    logic                       frame_end;
    logic                       load;
    logic [PIXEL_WIDTH_OUT-1:0] top_new;
    logic [PIXEL_WIDTH_OUT-1:0] mid_new;
    logic [PIXEL_WIDTH_OUT-1:0] core_mag;

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // In IDLE, only a start-of-frame pixel is processed; everything else is
    // accepted and dropped. A sof pixel in any state restarts at (0,0).
    always_comb begin
        take      = accept && (sof_i || (state != ST_IDLE));
        eff_col   = sof_i ? '0 : col;
        eff_row   = sof_i ? '0 : row;
        line_end  = (eff_col == LAST_COL);
        frame_end = line_end && (eff_row == LAST_ROW);
        next_col  = line_end ? '0 : eff_col + COL_W'(1);
        next_row  = eff_row;
        if (line_end)
            next_row = frame_end ? '0 : eff_row + ROW_W'(1);
        load      = take && (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
        top_new   = lb0[eff_col];
        mid_new   = lb1[eff_col];
    end

    // Core sees the window as it will be after this pixel shifts in.
    sobel_core u_core (
        .i0  (win[0][1]),
        .i1  (win[0][2]),
        .i2  (top_new),
        .i3  (win[1][1]),
        .i4  (win[1][2]),
        .i5  (mid_new),
        .i6  (win[2][1]),
        .i7  (win[2][2]),
        .i8  (in_pixel_i),
        .mag (core_mag)
    );

    // Line buffers carry no reset: each entry is written on row 0/1 before
    // any window that reads it can produce an output.
    always_ff @(posedge clk_i) begin
        if (take) begin
            lb0[eff_col] <= mid_new;
            lb1[eff_col] <= in_pixel_i;
        end
    end

    // FSM, raster counters, window and output register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            out_valid_o  <= 1'b0;
            out_pixel_o  <= '0;
            frame_done_o <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            frame_done_o <= 1'b0;

            // A downstream handshake empties the slot unless a new result
            // lands in the same cycle, which the load below overrides.
            if (out_valid_o && out_ready_i)
                out_valid_o <= 1'b0;

            if (take) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= top_new;
                win[1][2] <= mid_new;
                win[2][2] <= in_pixel_i;

                col <= next_col;
                row <= next_row;

                if (load) begin
                    out_pixel_o <= core_mag;
                    out_valid_o <= 1'b1;
                end

                if (sof_i) begin
                    state <= ST_PRIME;
                end else begin
                    case (state)
                        ST_PRIME: begin
                            if (line_end && (eff_row == ROW_W'(1)))
                                state <= ST_RUN;
                        end
                        ST_RUN: begin
                            if (frame_end) begin
                                state        <= ST_IDLE;
                                frame_done_o <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench for sobel_stream_ctrl with a 5x4 frame.
module tb_sobel_stream_ctrl;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk_i = 1'b0;
    logic       nreset_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_pixel_i = '0;
    logic       sof_i = 1'b0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [7:0] out_pixel_o;
    logic       frame_done_o;

    sobel_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_pixel_i   (in_pixel_i),
        .sof_i        (sof_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pixel_o  (out_pixel_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole-frame image plus textbook Sobel on it.
    int  fr [H][W];
    int  exp_q[$];
    int  got[$];
    bit  m_active = 0;
    int  m_r = 0;
    int  m_c = 0;
    bit  fd_next = 0;
    int  done_cnt = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sobel_ref(input int r, input int c);
        int gx, gy, m;
        gx = (fr[r-2][c] + 2*fr[r-1][c] + fr[r][c])
           - (fr[r-2][c-2] + 2*fr[r-1][c-2] + fr[r][c-2]);
        gy = (fr[r][c-2] + 2*fr[r][c-1] + fr[r][c])
           - (fr[r-2][c-2] + 2*fr[r-2][c-1] + fr[r-2][c]);
        m = iabs(gx) + iabs(gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic model_accept(input int p, input bit s);
        if (s) begin
            m_active = 1;
            m_r = 0;
            m_c = 0;
        end
        if (m_active) begin
            fr[m_r][m_c] = p;
            if (m_r >= 2 && m_c >= 2)
                exp_q.push_back(sobel_ref(m_r, m_c));
            if (m_c == W-1) begin
                m_c = 0;
                if (m_r == H-1) begin
                    m_r = 0;
                    m_active = 0;
                    fd_next = 1;
                end else begin
                    m_r++;
                end
            end else begin
                m_c++;
            end
        end
    endtask

    // Monitor: mid-cycle sampling of both handshakes against the model.
    always @(negedge clk_i) begin
        if (!nreset_i) begin
            exp_q.delete();
            m_active = 0;
            m_r = 0;
            m_c = 0;
            fd_next = 0;
            chk("rst_out_valid", out_valid_o, 0);
            chk("rst_frame_done", frame_done_o, 0);
        end else begin
            chk("frame_done", frame_done_o, fd_next);
            if (frame_done_o) done_cnt++;
            chk("out_valid", out_valid_o, (exp_q.size() != 0) ? 1 : 0);
            fd_next = 0;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() > 0) begin
                    chk("result", out_pixel_o, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got.push_back(int'(out_pixel_o));
            end
            if (in_valid_i && in_ready_o)
                model_accept(int'(in_pixel_i), sof_i);
        end
    end

    // Downstream ready: optional stall window at a result, or random throttling.
    int stall_left = 0;
    bit stall_chk  = 0;
    int stall_val  = 0;
    bit rand_ready = 0;

    always begin
        @(posedge clk_i);
        #1;
        if (stall_left > 0 && out_valid_o) begin
            out_ready_i = 1'b0;
            stall_left--;
            #1;
            if (stall_chk) begin
                chk("stall_pixel", out_pixel_o, stall_val);
                chk("stall_in_ready", in_ready_o, 0);
            end
        end else if (rand_ready) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready_i = 1'b1;
        end
    end

    task automatic push_pixel(input logic [7:0] p, input logic s);
        int waited;
        waited = 0;
        in_valid_i = 1'b1;
        in_pixel_i = p;
        sof_i      = s;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL accept_timeout: in_ready_o stayed %0d, expected 1", in_ready_o);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        sof_i      = 1'b0;
    endtask

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return 8'(c);
            2:       return (c < 2) ? 8'd0 : 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                push_pixel(pix_of(kind, r, c), (r == 0 && c == 0));
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(posedge clk_i);
                    #1;
                end
            end
    endtask

    task automatic drain();
        int n;
        n = 0;
        repeat (3) @(posedge clk_i);
        while ((out_valid_o || exp_q.size() != 0) && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: out_valid_o %0d, expected 0", out_valid_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        int             kind;
        int             stall;
        int             exp_cnt;
        logic [5:0][7:0] exp_res;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{kind: 0, stall: 0, exp_cnt: 6, exp_res: {6{8'd0}}};
        vecs[1] = '{kind: 1, stall: 0, exp_cnt: 6, exp_res: {6{8'd8}}};
        vecs[2] = '{kind: 2, stall: 0, exp_cnt: 6,
                    exp_res: {8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255}};
        vecs[3] = '{kind: 1, stall: 5, exp_cnt: 6, exp_res: {6{8'd8}}};

        // Reset state
        #3;
        chk("reset_out_valid", out_valid_o, 0);
        chk("reset_out_pixel", out_pixel_o, 0);
        chk("reset_frame_done", frame_done_o, 0);
        chk("reset_in_ready", in_ready_o, 1);
        repeat (2) @(posedge clk_i);
        #3;
        nreset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            got.delete();
            done_cnt   = 0;
            stall_left = vecs[v].stall;
            stall_chk  = (vecs[v].stall > 0);
            stall_val  = 8;
            send_frame(vecs[v].kind, 0);
            drain();
            chk("vec_count", got.size(), vecs[v].exp_cnt);
            for (int k = 0; k < got.size() && k < 6; k++)
                chk("vec_result", got[k], int'(vecs[v].exp_res[k]));
            chk("vec_done_cnt", done_cnt, 1);
            stall_chk = 0;
        end

        // Frame abort: sof reappears at (2,1) and starts a full uniform frame
        got.delete();
        done_cnt = 0;
        for (int i = 0; i < 11; i++)
            push_pixel(8'd100, (i == 0));
        repeat (3) @(posedge clk_i);
        #1;
        chk("abort_no_done", done_cnt, 0);
        send_frame(0, 0);
        drain();
        chk("abort_count", got.size(), 6);
        for (int k = 0; k < got.size(); k++)
            chk("abort_result", got[k], 0);
        chk("abort_done_cnt", done_cnt, 1);

        // Async reset mid-RUN with a result held by backpressure
        got.delete();
        done_cnt   = 0;
        stall_left = 1000;
        for (int i = 0; i < 13; i++)
            push_pixel(pix_of(1, i / W, i % W), (i == 0));
        chk("pre_reset_valid", out_valid_o, 1);
        #2;
        nreset_i = 1'b0;
        #1;
        chk("async_out_valid", out_valid_o, 0);
        chk("async_in_ready", in_ready_o, 1);
        chk("async_out_pixel", out_pixel_o, 0);
        stall_left = 0;
        repeat (2) @(posedge clk_i);
        #3;
        nreset_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 7; i++)
            push_pixel(8'($urandom_range(0, 255)), 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("discard_out_valid", out_valid_o, 0);
        chk("discard_count", got.size(), 0);
        send_frame(1, 0);
        drain();
        chk("post_reset_count", got.size(), 6);
        for (int k = 0; k < got.size(); k++)
            chk("post_reset_result", got[k], 8);
        chk("post_reset_done", done_cnt, 1);

        // Random frames, random gaps and throttling, checked by the model
        rand_ready = 1;
        for (int f = 0; f < 3; f++) begin
            got.delete();
            done_cnt = 0;
            send_frame(3, 1);
            drain();
            chk("rand_count", got.size(), 6);
            chk("rand_done_cnt", done_cnt, 1);
        end
        rand_ready = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/sobel_stream_ctrl.md
# sobel_stream_ctrl

- Streaming controller that sequences the combinational `sobel_core` across a raster-scan grayscale frame.
- Accepts one pixel per handshake and keeps two line buffers plus a 3x3 window register.
- Feeds the window to an internal `sobel_core` instance and registers each edge magnitude behind a valid/ready output handshake.
- Sits between the grayscale converter stream and the output serializer.

## Interface
- `IMG_WIDTH`, default 16: pixels per line; must be ≥ 3.
- `IMG_HEIGHT`, default 16: lines per frame; must be ≥ 3.
- Pixel width is the shared `PIXEL_WIDTH_OUT` (8); clamp value is the shared `MAX_PIXEL_VAL`.
- `clk_i` in 1: single clock, rising edge.
- `nreset_i` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: input pixel valid.
- `in_ready_o` out 1: controller can accept a pixel.
- `in_pixel_i` in `PIXEL_WIDTH_OUT`: grayscale pixel, raster order.
- `sof_i` in 1: qualifies the current input pixel as frame pixel (0,0).
- `out_valid_o` out 1: `out_pixel_o` holds a result.
- `out_ready_i` in 1: downstream accepts the result.
- `out_pixel_o` out `PIXEL_WIDTH_OUT`: Sobel magnitude, clamped.
- `frame_done_o` out 1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- **Accept:** a pixel is accepted when `in_valid_i && in_ready_o`; nothing changes on a non-accept cycle.
- **Ready rule:** `in_ready_o = !out_valid_o || out_ready_i`, combinational.
- **Counters:** `col` counts 0..`IMG_WIDTH`-1 and `row` counts 0..`IMG_HEIGHT`-1.
  - On accept, `col` increments and wraps to 0, incrementing `row`.
- **State machine:** IDLE, PRIME, RUN.
  - IDLE: pixels are accepted and discarded unless `sof_i=1`. A `sof_i` pixel is processed as (0,0), and the FSM moves to PRIME.
  - PRIME: `row` < 2; line buffers fill and no output is produced. Moves to RUN on accepting pixel (1, `IMG_WIDTH`-1).
  - RUN: `row` ≥ 2. Accepting (`IMG_HEIGHT`-1, `IMG_WIDTH`-1) returns the FSM to IDLE and pulses `frame_done_o` the next cycle.
  - Accepted `sof_i=1` in PRIME or RUN aborts the current frame: that pixel becomes (0,0), the FSM goes to PRIME, and `frame_done_o` is not pulsed.
- **Buffers:** `lb0` holds line r-2 and `lb1` holds line r-1. On accept, `lb0[col] <= lb1[col]` and `lb1[col] <= pixel`.
- **Window shift:** on accept, each window row shifts left.
  - The new right column is {`lb0[col]`, `lb1[col]`, pixel} (top to bottom).
  - `sobel_core` inputs i0..i8 are the next-window values in row-major order: i0 is top-left (oldest line, oldest column) and i8 is the incoming pixel.
- **Output load:** on an accept with `row` ≥ 2 and `col` ≥ 2 (pre-increment values), `out_pixel_o <= sobel_core` output and `out_valid_o <= 1`.
- **Output clear:** when `out_ready_i && out_valid_o` and no new load occurs, `out_valid_o <= 0`. A simultaneous handshake and load keeps `out_valid_o` at 1 with the new data.
- **Border pixels** produce no output. Each frame yields exactly (`IMG_WIDTH`-2)·(`IMG_HEIGHT`-2) results.
- **Arithmetic:** `sobel_core` computes |Gx|+|Gy|. Sums ≥ 2^`PIXEL_WIDTH_OUT` clamp to `MAX_PIXEL_VAL`-1 (255).

## Timing
- **Reset values:** `out_valid_o`=0, `out_pixel_o`=0, `frame_done_o`=0, FSM=IDLE, counters=0, window registers=0. `in_ready_o`=1 while reset is asserted.
- **Line buffers** are not reset; every entry is rewritten before it is read.
- **Latency:** the result for a window is valid the cycle after its bottom-right pixel is accepted.
- **Throughput:** one pixel per cycle when `out_ready_i` is held at 1.
- **Stall:** while `out_valid_o && !out_ready_i`, `out_pixel_o` is stable, `in_ready_o`=0, and no pixel is lost.
- **Reset mid-frame:** takes effect immediately and asynchronously. The partial frame is discarded; the next `sof_i` frame is correct.

## Structure
- `PIXEL_WIDTH_OUT`, `MAX_PIXEL_VAL`, `IMG_WIDTH`/`IMG_HEIGHT` defaults, and the FSM state typedef belong in `parameters.svh`.
- One sub-module: `sobel_core`, instantiated unchanged.
- Line buffers, window registers, counters, FSM and output register are all inside `sobel_stream_ctrl`.

## Test plan
All scenarios use `IMG_WIDTH`=5, `IMG_HEIGHT`=4 unless stated.

- **Uniform frame:** all pixels 100, `out_ready_i`=1 → 6 results, all 0. `frame_done_o` pulses once, one cycle after the 20th accept.
- **Horizontal ramp:** pixel = col (0..4) → 6 results, each 8 (Gx=8, Gy=0).
- **Vertical edge:** columns 0,0,255,255,255 → results are 255 (clamped), 255, 0 per row, for 2 rows.
- **Backpressure:** ramp frame with `out_ready_i` low for 5 cycles at the first result.
  - `out_pixel_o` holds 8 and `in_ready_o`=0 during the stall.
  - All 6 results are delivered once `out_ready_i` returns high, with the same values as the unstalled run.
- **Frame abort:** `sof_i` reasserted at pixel (2,1), then a full uniform frame → no `frame_done_o` for the aborted frame, then 6 zeros and one `frame_done_o`.
- **Async reset:** `nreset_i` pulsed low mid-RUN with `out_valid_o`=1.
  - `out_valid_o` drops immediately.
  - Pixels without `sof_i` are discarded.
  - The next `sof_i` ramp frame yields 6 results of 8.
